sr_ff_bank: RTL and testbench

SR_FF_BANK -- requirements
Module: sr_ff_bank

---
 rtl/sr_ff_pkg.sv | 34 +++
 rtl/sr_ff_cell.sv | 53 +++++
 rtl/sr_ff_bank.sv | 62 ++++++
 tb/tb_sr_ff_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared types and next-state rule for the SR flip-flop bank.
// The conflict mode is a parameter so each bank resolves S=R=1 one fixed way.
package sr_ff_pkg;

   typedef enum logic [1:0] {
      SR_SET_DOM = 2'd0,
      SR_RST_DOM = 2'd1,
      SR_HOLD    = 2'd2,
      SR_TOGGLE  = 2'd3
   } sr_mode_e;

   // Next Q for one channel with the update enabled.
   function automatic logic sr_next(input logic q, input logic s, input logic r,
                                    input sr_mode_e mode);
      logic nq;
      nq = q;
      unique case ({s, r})
         2'b10:   nq = 1'b1;
         2'b01:   nq = 1'b0;
         2'b00:   nq = q;
         default: begin
            unique case (mode)
               SR_SET_DOM: nq = 1'b1;
               SR_RST_DOM: nq = 1'b0;
               SR_HOLD:    nq = q;
               SR_TOGGLE:  nq = ~q;
               default:    nq = q;
            endcase
         end
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: state bit, registered edge pulses and sticky conflict flag.
// The conflict output is combinational so the top can OR all channels this cycle.
module sr_ff_cell
   import sr_ff_pkg::*;
#(
   parameter sr_mode_e MODE = SR_SET_DOM
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic clr_conflict,
   output logic q,
   output logic q_rise,
   output logic q_fall,
   output logic conflict_sticky,
   output logic conflict
);

   logic q_next;

   assign conflict = en & s & r;
   assign q_next   = sr_next(q, s, r, MODE);

   // Pulses are computed from the pre-edge Q so reset never produces a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= 1'b0;
         q_rise <= 1'b0;
         q_fall <= 1'b0;
      end else if (en) begin
         q      <= q_next;
         q_rise <= ~q & q_next;
         q_fall <= q & ~q_next;
      end else begin
         q_rise <= 1'b0;
         q_fall <= 1'b0;
      end
   end

   // Clear first, then apply this cycle's conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_sticky <= 1'b0;
      end else if (clr_conflict) begin
         conflict_sticky <= conflict;
      end else if (conflict) begin
         conflict_sticky <= 1'b1;
      end
   end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of independent SR flip-flops with a shared saturating conflict counter.
// The counter advances once per cycle in which any channel conflicts.
module sr_ff_bank
   import sr_ff_pkg::*;
#(
   parameter int       CHANNELS = 8,
   parameter sr_mode_e MODE     = SR_SET_DOM,
   parameter int       CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] S,
   input  logic [CHANNELS-1:0] R,
   input  logic                en,
   input  logic                clr_conflict,
   output logic [CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0] Qn,
   output logic [CHANNELS-1:0] q_rise,
   output logic [CHANNELS-1:0] q_fall,
   output logic [CHANNELS-1:0] conflict_sticky,
   output logic [CNT_W-1:0]    conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CHANNELS-1:0] conflict;
   logic                any_conflict;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
      sr_ff_cell #(
         .MODE (MODE)
      ) u_cell (
         .clk             (clk),
         .rst             (rst),
         .en              (en),
         .s               (S[i]),
         .r               (R[i]),
         .clr_conflict    (clr_conflict),
         .q               (Q[i]),
         .q_rise          (q_rise[i]),
         .q_fall          (q_fall[i]),
         .conflict_sticky (conflict_sticky[i]),
         .conflict        (conflict[i])
      );
   end

   assign Qn           = ~Q;
   assign any_conflict = |conflict;

   // A clear concurrent with a conflict restarts the count at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (clr_conflict) begin
         conflict_cnt <= any_conflict ? CNT_ONE : '0;
      end else if (any_conflict && (conflict_cnt != CNT_MAX)) begin
         conflict_cnt <= conflict_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four instances (one per conflict mode) on shared stimulus,
// a vector table with fixed expectations, directed corner sequences and a scoreboard.
module tb_sr_ff_bank;
   import sr_ff_pkg::*;

   localparam int NI = 4;
   localparam int EW = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s   = '0;
   logic [7:0] r   = '0;
   logic       en  = 1'b1;
   logic       clr = 1'b0;

   logic [7:0] dut_q    [NI];
   logic [7:0] dut_qn   [NI];
   logic [7:0] dut_rise [NI];
   logic [7:0] dut_fall [NI];
   logic [7:0] dut_st   [NI];
   logic [7:0] dut_cnt  [NI];
   logic [7:0] cnt_set, cnt_rst, cnt_hold;
   logic [2:0] cnt_tog;

   int checks = 0;
   int fails  = 0;

   logic [NI*EW-1:0] exp_q[$];

   sr_mode_e   m_mode [NI] = '{SR_SET_DOM, SR_RST_DOM, SR_HOLD, SR_TOGGLE};
   int         m_max  [NI] = '{255, 255, 255, 7};
   logic [7:0] m_q    [NI];
   logic [7:0] m_rise [NI];
   logic [7:0] m_fall [NI];
   logic [7:0] m_st   [NI];
   int         m_cnt  [NI];

   always #5 clk = ~clk;

   sr_ff_bank #(.CHANNELS(8), .MODE(SR_SET_DOM), .CNT_W(8)) u_set (
      .clk(clk), .rst(rst), .S(s), .R(r), .en(en), .clr_conflict(clr),
      .Q(dut_q[0]), .Qn(dut_qn[0]), .q_rise(dut_rise[0]), .q_fall(dut_fall[0]),
      .conflict_sticky(dut_st[0]), .conflict_cnt(cnt_set));
   sr_ff_bank #(.CHANNELS(8), .MODE(SR_RST_DOM), .CNT_W(8)) u_rst (
      .clk(clk), .rst(rst), .S(s), .R(r), .en(en), .clr_conflict(clr),
      .Q(dut_q[1]), .Qn(dut_qn[1]), .q_rise(dut_rise[1]), .q_fall(dut_fall[1]),
      .conflict_sticky(dut_st[1]), .conflict_cnt(cnt_rst));
   sr_ff_bank #(.CHANNELS(8), .MODE(SR_HOLD), .CNT_W(8)) u_hold (
      .clk(clk), .rst(rst), .S(s), .R(r), .en(en), .clr_conflict(clr),
      .Q(dut_q[2]), .Qn(dut_qn[2]), .q_rise(dut_rise[2]), .q_fall(dut_fall[2]),
      .conflict_sticky(dut_st[2]), .conflict_cnt(cnt_hold));
   sr_ff_bank #(.CHANNELS(8), .MODE(SR_TOGGLE), .CNT_W(3)) u_tog (
      .clk(clk), .rst(rst), .S(s), .R(r), .en(en), .clr_conflict(clr),
      .Q(dut_q[3]), .Qn(dut_qn[3]), .q_rise(dut_rise[3]), .q_fall(dut_fall[3]),
      .conflict_sticky(dut_st[3]), .conflict_cnt(cnt_tog));

   always_comb begin
      dut_cnt[0] = cnt_set;
      dut_cnt[1] = cnt_rst;
      dut_cnt[2] = cnt_hold;
      dut_cnt[3] = {5'b0, cnt_tog};
   end

   // Reference rule written straight from the truth table.
   function automatic logic model_bit(input logic q, input logic sb, input logic rb,
                                      input sr_mode_e m);
      if (sb && !rb) return 1'b1;
      if (!sb && rb) return 1'b0;
      if (!sb && !rb) return q;
      if (m == SR_SET_DOM) return 1'b1;
      if (m == SR_RST_DOM) return 1'b0;
      if (m == SR_TOGGLE) return ~q;
      return q;
   endfunction

   task automatic check(input string name, input int inst, input logic [7:0] got,
                        input logic [7:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s inst=%0d got=%h exp=%h", name, inst, got, want);
      end
   endtask

   // Advance the model on the currently driven inputs, run one clock, compare.
   task automatic tick();
      logic [NI*EW-1:0] e;
      logic [NI*EW-1:0] g;
      logic [7:0]       conf;
      logic [7:0]       nq;
      conf = en ? (s & r) : 8'h00;
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            m_q[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_st[k] = '0; m_cnt[k] = 0;
         end else begin
            if (en) begin
               for (int b = 0; b < 8; b++) nq[b] = model_bit(m_q[k][b], s[b], r[b], m_mode[k]);
               m_rise[k] = ~m_q[k] & nq;
               m_fall[k] = m_q[k] & ~nq;
               m_q[k]    = nq;
            end else begin
               m_rise[k] = '0;
               m_fall[k] = '0;
            end
            m_st[k] = clr ? conf : (m_st[k] | conf);
            if (clr) m_cnt[k] = (conf != 0) ? 1 : 0;
            else if (conf != 0 && m_cnt[k] < m_max[k]) m_cnt[k]++;
         end
         e[k*EW +: EW] = {m_q[k], m_rise[k], m_fall[k], m_st[k], 8'(m_cnt[k])};
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
         check("q",      k, dut_q[k],    g[k*EW+32 +: 8]);
         check("qn",     k, dut_qn[k],   ~g[k*EW+32 +: 8]);
         check("rise",   k, dut_rise[k], g[k*EW+24 +: 8]);
         check("fall",   k, dut_fall[k], g[k*EW+16 +: 8]);
         check("sticky", k, dut_st[k],   g[k*EW+8 +: 8]);
         check("cnt",    k, dut_cnt[k],  g[k*EW +: 8]);
      end
   endtask

   task automatic drive(input logic [7:0] sv, input logic [7:0] rv, input logic env,
                        input logic clrv, input logic rstv);
      s = sv; r = rv; en = env; clr = clrv; rst = rstv;
   endtask

   typedef struct {
      logic [7:0] s, r;
      logic       en, clr, rst;
      logic [7:0] q, rise, fall, cnt;
   } vec_t;

   vec_t tbl[10];
   int   tog_pat[4] = '{1, 0, 1, 0};

   initial begin
      //          s      r      en    clr   rst   q      rise   fall   cnt
      tbl[0] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[2] = '{8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 8'h00, 8'h00};
      tbl[3] = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 8'h01, 8'h00};
      tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00};
      tbl[5] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00};
      tbl[6] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00};
      tbl[7] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00};
      tbl[8] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFB, 8'h00, 8'h00};
      tbl[9] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].s, tbl[i].r, tbl[i].en, tbl[i].clr, tbl[i].rst);
         tick();
         check("tbl_q",    i, dut_q[0],    tbl[i].q);
         check("tbl_qn",   i, dut_qn[0],   ~tbl[i].q);
         check("tbl_rise", i, dut_rise[0], tbl[i].rise);
         check("tbl_fall", i, dut_fall[0], tbl[i].fall);
         check("tbl_cnt",  i, dut_cnt[0],  tbl[i].cnt);
      end

      // One conflict from Q=0 in every mode.
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); tick();
      drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b0); tick();
      check("mode_q", 0, dut_q[0], 8'h01);
      check("mode_q", 1, dut_q[1], 8'h00);
      check("mode_q", 2, dut_q[2], 8'h00);
      check("mode_q", 3, dut_q[3], 8'h01);
      for (int k = 0; k < NI; k++) begin
         check("mode_sticky", k, dut_st[k], 8'h01);
         check("mode_cnt",    k, dut_cnt[k], 8'h01);
      end

      // Toggle held four cycles.
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); tick();
      for (int i = 0; i < 4; i++) begin
         drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b0); tick();
         check("tog_q",    i, dut_q[3],    8'(tog_pat[i]));
         check("tog_rise", i, dut_rise[3], 8'(tog_pat[i]));
         check("tog_fall", i, dut_fall[3], 8'(1 - tog_pat[i]));
      end

      // Saturation, then clear with a concurrent conflict, then clear while disabled.
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); tick();
      for (int i = 0; i < 10; i++) begin
         drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b0); tick();
      end
      check("sat_cnt", 3, dut_cnt[3], 8'd7);
      check("sat_cnt", 0, dut_cnt[0], 8'd10);
      drive(8'h03, 8'h03, 1'b1, 1'b1, 1'b0); tick();
      check("clr_cnt",    3, dut_cnt[3], 8'd1);
      check("clr_sticky", 3, dut_st[3],  8'h03);
      drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b0); tick();
      check("clr_off_cnt",    0, dut_cnt[0], 8'd0);
      check("clr_off_sticky", 0, dut_st[0],  8'h00);

      // Reset while a toggling channel is high: no fall pulse.
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); tick();
      drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b0); tick();
      check("mid_q", 3, dut_q[3], 8'h01);
      drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b1); tick();
      check("rst_fall", 3, dut_fall[3], 8'h00);
      check("rst_q",    3, dut_q[3],    8'h00);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 200; i++) begin
         drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 39) == 0));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
